// File: rtl/rand_pkg.sv
// Shared types and constants for the random-source sequencer and its LFSR.
package rand_pkg;
    localparam int WIDTH = 9;
    localparam logic [WIDTH-1:0] LFSR_TAPS = 9'b1_0110_1001;
    localparam logic [WIDTH-1:0] LFSR_INIT = 9'b1_1010_1110;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        STEP  = 2'd2
    } state_t;
endpackage

// File: rtl/lfsr_step.sv
// Galois LFSR register with reload and step controls; reload wins over step.
module lfsr_step
    import rand_pkg::*;
#(
    parameter int               WIDTH    = rand_pkg::WIDTH,
    parameter logic [WIDTH-1:0] TAPS     = LFSR_TAPS,
    parameter logic [WIDTH-1:0] INIT_VAL = LFSR_INIT
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_step,
    input  logic             i_load,
    output logic [WIDTH-1:0] o_reg
);
    logic [WIDTH-1:0] lfsr_reg;
    logic [WIDTH-1:0] lfsr_next;
    logic [WIDTH-1:0] shift_next;

    assign shift_next[0] = lfsr_reg[WIDTH-1];

    // Bit i takes bit i-1, xored with the MSB where the mirrored tap is set.
    generate
        for (genvar gi = 1; gi < WIDTH; gi++) begin : g_bit
            if (TAPS[WIDTH-1-gi]) begin : g_tap
                assign shift_next[gi] = lfsr_reg[gi-1] ^ lfsr_reg[WIDTH-1];
            end else begin : g_plain
                assign shift_next[gi] = lfsr_reg[gi-1];
            end
        end
    endgenerate

    always_comb begin
        lfsr_next = lfsr_reg;
        if (i_load) begin
            lfsr_next = INIT_VAL;
        end else if (i_step) begin
            // An all-zero register would never leave zero, so restart it.
            lfsr_next = (lfsr_reg == '0) ? INIT_VAL : shift_next;
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            lfsr_reg <= INIT_VAL;
        end else begin
            lfsr_reg <= lfsr_next;
        end
    end

    assign o_reg = lfsr_reg;
endmodule

// File: rtl/rand_share_ctrl.sv
// Round-robin arbiter handing out fresh LFSR values; steps the LFSR after each
// grant and free-runs it slowly while idle.
module rand_share_ctrl
    import rand_pkg::*;
#(
    parameter int               NUM_REQ  = 2,
    parameter int               WIDTH    = rand_pkg::WIDTH,
    parameter logic [WIDTH-1:0] TAPS     = LFSR_TAPS,
    parameter logic [WIDTH-1:0] INIT_VAL = LFSR_INIT,
    parameter int               WARMUP   = 2,
    parameter int               IDLE_DIV = 1000
) (
    input  logic               i_Clk,
    input  logic               i_Rst,
    input  logic [1:0]         i_state,
    input  logic [NUM_REQ-1:0] i_req,
    output logic [NUM_REQ-1:0] o_ack,
    output logic [WIDTH-1:0]   o_data,
    output logic               o_busy
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (IDLE_DIV > 1) ? $clog2(IDLE_DIV) : 1;
    localparam logic [CNT_W-1:0] IDLE_LAST = (IDLE_DIV > 0) ? CNT_W'(IDLE_DIV - 1) : '0;
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_REQ - 1);
    localparam logic [IDX_W:0]   REQ_COUNT = (IDX_W+1)'(NUM_REQ);

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   ptr_reg, ptr_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;
    logic [CNT_W-1:0]   idle_cnt_reg, idle_cnt_next;
    logic [3:0]         step_cnt_reg, step_cnt_next;
    logic [NUM_REQ-1:0] ack_reg, ack_next;
    logic [WIDTH-1:0]   data_reg, data_next;
    logic               busy_reg, busy_next;

    logic               game_run;
    logic               lfsr_step_en;
    logic               lfsr_load;
    logic [WIDTH-1:0]   lfsr_val;
    logic [NUM_REQ-1:0] rot_req;
    logic [IDX_W-1:0]   pick_off;
    logic               pick_found;
    logic [IDX_W:0]     pick_sum;
    logic [IDX_W-1:0]   pick_idx;

    assign game_run = (i_state != 2'd0);

    lfsr_step #(
        .WIDTH    (WIDTH),
        .TAPS     (TAPS),
        .INIT_VAL (INIT_VAL)
    ) u_lfsr (
        .i_Clk  (i_Clk),
        .i_Rst  (i_Rst),
        .i_step (lfsr_step_en),
        .i_load (lfsr_load),
        .o_reg  (lfsr_val)
    );

    // Rotate requests so the pointer sits at bit 0, then take the lowest set bit.
    assign rot_req = NUM_REQ'({i_req, i_req} >> ptr_reg);

    always_comb begin
        pick_off   = '0;
        pick_found = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot_req[k]) begin
                pick_off   = IDX_W'(k);
                pick_found = 1'b1;
            end
        end
    end

    assign pick_sum = {1'b0, ptr_reg} + {1'b0, pick_off};
    assign pick_idx = (pick_sum >= REQ_COUNT) ? IDX_W'(pick_sum - REQ_COUNT) : pick_sum[IDX_W-1:0];

    always_comb begin
        state_next    = state_reg;
        ptr_next      = ptr_reg;
        idx_next      = idx_reg;
        idle_cnt_next = idle_cnt_reg;
        step_cnt_next = step_cnt_reg;
        ack_next      = '0;
        data_next     = '0;
        lfsr_step_en  = 1'b0;
        lfsr_load     = 1'b0;
        if (!game_run) begin
            state_next    = IDLE;
            ptr_next      = '0;
            idle_cnt_next = '0;
            step_cnt_next = '0;
            lfsr_load     = 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    // A grant takes the pre-step value and suppresses the free-run step.
                    if (pick_found) begin
                        idx_next   = pick_idx;
                        ack_next   = NUM_REQ'(1) << pick_idx;
                        data_next  = lfsr_val;
                        state_next = GRANT;
                    end else if (IDLE_DIV != 0) begin
                        if (idle_cnt_reg == IDLE_LAST) begin
                            idle_cnt_next = '0;
                            lfsr_step_en  = 1'b1;
                        end else begin
                            idle_cnt_next = idle_cnt_reg + CNT_W'(1);
                        end
                    end
                end
                GRANT: begin
                    ptr_next      = (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_W'(1);
                    step_cnt_next = 4'(WARMUP);
                    state_next    = STEP;
                end
                STEP: begin
                    lfsr_step_en  = 1'b1;
                    step_cnt_next = step_cnt_reg - 4'd1;
                    if (step_cnt_reg <= 4'd1) begin
                        state_next    = IDLE;
                        idle_cnt_next = '0;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
        busy_next = game_run && (state_next != IDLE);
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_reg    <= IDLE;
            ptr_reg      <= '0;
            idx_reg      <= '0;
            idle_cnt_reg <= '0;
            step_cnt_reg <= '0;
            ack_reg      <= '0;
            data_reg     <= '0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ptr_reg      <= ptr_next;
            idx_reg      <= idx_next;
            idle_cnt_reg <= idle_cnt_next;
            step_cnt_reg <= step_cnt_next;
            ack_reg      <= ack_next;
            data_reg     <= data_next;
            busy_reg     <= busy_next;
        end
    end

    // Game state 0 silences the outputs in the same cycle it appears.
    assign o_ack  = game_run ? ack_reg : '0;
    assign o_data = (game_run && (ack_reg != '0)) ? data_reg : '0;
    assign o_busy = game_run & busy_reg;
endmodule

// File: tb/tb_rand_share_ctrl.sv
// Scoreboard bench: stimulus queues expected acks, negedge monitors compare.
module tb_rand_share_ctrl;
    typedef struct packed {
        logic [1:0] ack;
        logic [8:0] data;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [1:0] state0, state1;
    logic [1:0] req0, req1;
    logic [1:0] ack0, ack1;
    logic [8:0] data0, data1;
    logic       busy0, busy1;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int cyc0 = 0, cyc1 = 0;
    int last0 = -100, last1 = -100;
    int n;

    rand_share_ctrl #(.NUM_REQ(2), .WIDTH(9), .WARMUP(2), .IDLE_DIV(0)) u_dut0 (
        .i_Clk(clk), .i_Rst(rst), .i_state(state0), .i_req(req0),
        .o_ack(ack0), .o_data(data0), .o_busy(busy0)
    );

    rand_share_ctrl #(.NUM_REQ(2), .WIDTH(9), .WARMUP(2), .IDLE_DIV(4)) u_dut1 (
        .i_Clk(clk), .i_Rst(rst), .i_state(state1), .i_req(req1),
        .o_ack(ack1), .o_data(data1), .o_busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) begin
            passes++;
        end else begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input bit sel, input logic [1:0] a, input logic [8:0] d);
        if (sel) q1.push_back({a, d});
        else     q0.push_back({a, d});
    endtask

    // Waits (bounded) for an ack, then the granted requester drops its request.
    task automatic wait_ack(input bit sel, output int cnt);
        logic [1:0] a;
        cnt = 0;
        do begin
            @(posedge clk); #1;
            cnt++;
            a = sel ? ack1 : ack0;
        end while (a == 2'b00 && cnt < 40);
        check(sel ? "dut1_ack_seen" : "dut0_ack_seen", int'(a != 2'b00), 1);
        if (sel) req1 = req1 & ~a;
        else     req0 = req0 & ~a;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            cyc0++;
            if (ack0 != 2'b00) begin
                $display("dut0 cycle %0d ack=%b data=0x%03h", cyc0, ack0, data0);
                check("dut0_ack_gap_ok", int'(cyc0 - last0 >= 4), 1);
                last0 = cyc0;
                if (q0.size() == 0) begin
                    check("dut0_unexpected_ack", int'(ack0), 0);
                end else begin
                    e0 = q0.pop_front();
                    check("dut0_ack", int'(ack0), int'(e0.ack));
                    check("dut0_data", int'(data0), int'(e0.data));
                end
            end else begin
                check("dut0_data_zero", int'(data0), 0);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            cyc1++;
            if (ack1 != 2'b00) begin
                $display("dut1 cycle %0d ack=%b data=0x%03h", cyc1, ack1, data1);
                check("dut1_ack_gap_ok", int'(cyc1 - last1 >= 4), 1);
                last1 = cyc1;
                if (q1.size() == 0) begin
                    check("dut1_unexpected_ack", int'(ack1), 0);
                end else begin
                    e1 = q1.pop_front();
                    check("dut1_ack", int'(ack1), int'(e1.ack));
                    check("dut1_data", int'(data1), int'(e1.data));
                end
            end else begin
                check("dut1_data_zero", int'(data1), 0);
            end
        end
    end

    initial begin
        rst = 1'b0; state0 = 2'd1; state1 = 2'd0; req0 = 2'b00; req1 = 2'b00;

        // Asynchronous reset asserted between clock edges.
        @(posedge clk); #3;
        rst = 1'b1; #1;
        check("rst_ack", int'(ack0), 0);
        check("rst_data", int'(data0), 0);
        check("rst_busy", int'(busy0), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // First grant: one-cycle latency, initial value, busy for three cycles.
        @(posedge clk); #1;
        push(0, 2'b01, 9'h1AE); req0 = 2'b01;
        wait_ack(0, n);
        check("first_latency", n, 1);
        check("busy_in_grant", int'(busy0), 1);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            check("busy_after_grant", int'(busy0), int'(k < 3));
        end

        // Second grant sees a value two steps on.
        push(0, 2'b01, 9'h0E2); req0 = 2'b01;
        wait_ack(0, n);
        check("second_latency", n, 1);

        // Requester 1 alone: moves the pointer back to 0.
        push(0, 2'b10, 9'h0A5); req0 = 2'b10;
        wait_ack(0, n);

        // Both requesting, each dropping after its ack.
        push(0, 2'b01, 9'h1B9); push(0, 2'b10, 9'h0BE);
        req0 = 2'b11;
        wait_ack(0, n);
        wait_ack(0, n);

        // Both re-raising: strict alternation; requester 0 left pending at the end.
        push(0, 2'b01, 9'h1D5); push(0, 2'b10, 9'h10E);
        push(0, 2'b01, 9'h14F); push(0, 2'b10, 9'h04B);
        push(0, 2'b01, 9'h12C);
        req0 = 2'b11;
        for (int i = 0; i < 4; i++) begin
            wait_ack(0, n);
            if (i < 3) begin
                @(posedge clk); #1;
                req0 = 2'b11;
            end
        end
        wait_ack(0, n);

        // Game reset while stepping, with requester 1 waiting.
        req0 = 2'b10;
        @(posedge clk); #1;
        check("busy_before_game_reset", int'(busy0), 1);
        state0 = 2'd0; #1;
        check("game_reset_busy", int'(busy0), 0);
        check("game_reset_ack", int'(ack0), 0);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            check("game_reset_busy_hold", int'(busy0), 0);
            check("game_reset_ack_hold", int'(ack0), 0);
        end
        state0 = 2'd1;
        push(0, 2'b10, 9'h1AE);
        wait_ack(0, n);
        check("after_game_reset_latency", n, 1);

        // Idle free-run: eight idle cycles with a divide of four give two steps.
        @(posedge clk); #1;
        state1 = 2'd1;
        repeat (8) @(posedge clk);
        #1;
        push(1, 2'b01, 9'h0E2); req1 = 2'b01;
        wait_ack(1, n);
        check("freerun_latency", n, 1);

        // Request lands on the idle counter's terminal cycle.
        repeat (6) @(posedge clk);
        #1;
        push(1, 2'b01, 9'h0A5); req1 = 2'b01;
        wait_ack(1, n);
        check("terminal_latency", n, 1);
        @(posedge clk); #1;
        push(1, 2'b01, 9'h1B9); req1 = 2'b01;
        wait_ack(1, n);

        repeat (6) @(posedge clk);
        #1;
        check("dut0_queue_drained", q0.size(), 0);
        check("dut1_queue_drained", q1.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
